// File: rtl/misao_reg_stack_if.sv
// Operation handshake between the MISA-O core and a register-stack unit.
// The core drives requests as master; the stack answers as slave.
interface misao_reg_stack_if #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
);
    localparam int ARGW = (WIDTH / NIB > 1) ? $clog2(WIDTH / NIB) : 1;

    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [ARGW-1:0]  op_arg;
    logic             lk;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] acc_out;
    logic             res_valid;

    modport master (
        output op_valid, op_code, op_arg, lk, acc_in,
        input  op_ready, acc_out, res_valid
    );

    modport slave (
        input  op_valid, op_code, op_arg, lk, acc_in,
        output op_ready, acc_out, res_valid
    );
endinterface

// File: rtl/misao_reg_stack.sv
// Parametrised source/address register stack for the MISA-O core.
// Exchanges data with the accumulator; ROTR runs one nibble per cycle.
module misao_reg_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int NIB   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    misao_reg_stack_if.slave           sif,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       unf
);
    localparam int ARGW = (WIDTH / NIB > 1) ? $clog2(WIDTH / NIB) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, ROT} state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_SWAP  = 3'b001;
    localparam logic [2:0] OP_ROTS  = 3'b010;
    localparam logic [2:0] OP_ROTSB = 3'b011;
    localparam logic [2:0] OP_ROTR  = 3'b100;
    localparam logic [2:0] OP_PUSH  = 3'b101;
    localparam logic [2:0] OP_POP   = 3'b110;
    localparam logic [2:0] OP_CLRF  = 3'b111;

    state_t            state_q;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  cap_q;
    logic [ARGW-1:0]   steps_q;
    logic              ready_q;
    logic              rv_q;
    logic              start_rot;

    assign start_rot = (sif.op_code == OP_ROTR) && (sif.op_arg != '0);

    // Result of a single-cycle op if it were accepted this cycle
    always_comb begin
        for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        acc_d   = sif.acc_in;
        unique case (sif.op_code)
            OP_NOP, OP_ROTR: ;
            OP_SWAP: begin
                if (sif.lk) begin
                    acc_d     = regs_q[0];
                    regs_d[0] = sif.acc_in;
                end else begin
                    acc_d[NIB-1:0]     = regs_q[0][NIB-1:0];
                    regs_d[0][NIB-1:0] = sif.acc_in[NIB-1:0];
                end
            end
            OP_ROTS: begin
                for (int i = 0; i < DEPTH - 1; i++) regs_d[i] = regs_q[i+1];
                regs_d[DEPTH-1] = regs_q[0];
            end
            OP_ROTSB: begin
                for (int i = 1; i < DEPTH; i++) regs_d[i] = regs_q[i-1];
                regs_d[0] = regs_q[DEPTH-1];
            end
            OP_PUSH: begin
                for (int i = 1; i < DEPTH; i++) regs_d[i] = regs_q[i-1];
                regs_d[0] = sif.lk ? sif.acc_in
                                   : {{(WIDTH-NIB){1'b0}}, sif.acc_in[NIB-1:0]};
                if (count_q == CW'(DEPTH)) ovf_d = 1'b1;
                else                       count_d = count_q + CW'(1);
            end
            OP_POP: begin
                acc_d = sif.lk ? regs_q[0]
                               : {sif.acc_in[WIDTH-1:NIB], regs_q[0][NIB-1:0]};
                for (int i = 0; i < DEPTH - 1; i++) regs_d[i] = regs_q[i+1];
                regs_d[DEPTH-1] = '0;
                if (count_q == '0) unf_d = 1'b1;
                else               count_d = count_q - CW'(1);
            end
            OP_CLRF: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            acc_q   <= '0;
            cap_q   <= '0;
            steps_q <= '0;
            ready_q <= 1'b1;
            rv_q    <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sif.op_valid && ready_q) begin
                        if (start_rot) begin
                            state_q <= ROT;
                            steps_q <= sif.op_arg;
                            cap_q   <= sif.acc_in;
                            ready_q <= 1'b0;
                        end else begin
                            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
                            count_q <= count_d;
                            ovf_q   <= ovf_d;
                            unf_q   <= unf_d;
                            acc_q   <= acc_d;
                            rv_q    <= 1'b1;
                        end
                    end
                end
                ROT: begin
                    regs_q[0] <= {regs_q[0][WIDTH-NIB-1:0],
                                  regs_q[0][WIDTH-1:WIDTH-NIB]};
                    steps_q   <= steps_q - ARGW'(1);
                    if (steps_q == ARGW'(1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        acc_q   <= cap_q;
                        rv_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sif.op_ready  = ready_q;
    assign sif.acc_out   = acc_q;
    assign sif.res_valid = rv_q;
    assign top   = regs_q[0];
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
endmodule

// File: tb/tb_misao_reg_stack.sv
// Directed test bench for misao_reg_stack (WIDTH=16, DEPTH=2, NIB=4).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_misao_reg_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] top;
    logic [1:0]  count;
    logic        ovf;
    logic        unf;
    int          tests = 0;
    int          fails = 0;

    misao_reg_stack_if #(.WIDTH(16), .NIB(4)) sif ();

    misao_reg_stack #(.WIDTH(16), .DEPTH(2), .NIB(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .sif   (sif),
        .top   (top),
        .count (count),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one op for one edge; returns on the falling edge after acceptance
    task automatic issue(input logic [2:0] code, input logic [1:0] arg,
                         input logic l, input logic [15:0] acc);
        @(negedge clk);
        sif.op_valid = 1'b1;
        sif.op_code  = code;
        sif.op_arg   = arg;
        sif.lk       = l;
        sif.acc_in   = acc;
        @(negedge clk);
        sif.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (top !== 16'h0) begin
            fails++; $display("FAIL reset_top got %h want 0000", top);
        end
        tests++;
        if (count !== 2'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got c=%0d o=%b u=%b want 0/0/0", count, ovf, unf);
        end
        tests++;
        if (sif.acc_out !== 16'h0 || sif.res_valid !== 1'b0 || sif.op_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_hs got acc=%h rv=%b rdy=%b want 0000/0/1",
                     sif.acc_out, sif.res_valid, sif.op_ready);
        end
    endtask

    task automatic test_swap_ul();
        issue(3'b001, 2'd0, 1'b0, 16'hAAA1);
        tests++;
        if (sif.res_valid !== 1'b1 || sif.acc_out !== 16'hAAA0 || top !== 16'h0001) begin
            fails++;
            $display("FAIL swap_ul1 got rv=%b acc=%h top=%h want 1/aaa0/0001",
                     sif.res_valid, sif.acc_out, top);
        end
        @(negedge clk);
        tests++;
        if (sif.res_valid !== 1'b0 || sif.acc_out !== 16'hAAA0) begin
            fails++;
            $display("FAIL swap_pulse got rv=%b acc=%h want 0/aaa0", sif.res_valid, sif.acc_out);
        end
        issue(3'b001, 2'd0, 1'b0, 16'hAAA2);
        tests++;
        if (sif.acc_out !== 16'hAAA1 || top !== 16'h0002) begin
            fails++;
            $display("FAIL swap_ul2 got acc=%h top=%h want aaa1/0002", sif.acc_out, top);
        end
    endtask

    task automatic test_push_rot();
        issue(3'b101, 2'd0, 1'b1, 16'hBBBB);
        issue(3'b101, 2'd0, 1'b1, 16'hCCCC);
        tests++;
        if (count !== 2'd2 || top !== 16'hCCCC || ovf !== 1'b0) begin
            fails++;
            $display("FAIL push2 got c=%0d top=%h o=%b want 2/cccc/0", count, top, ovf);
        end
        issue(3'b010, 2'd0, 1'b1, 16'h0);
        tests++;
        if (top !== 16'hBBBB) begin
            fails++; $display("FAIL rots got %h want bbbb", top);
        end
        issue(3'b011, 2'd0, 1'b1, 16'h0);
        tests++;
        if (top !== 16'hCCCC) begin
            fails++; $display("FAIL rotsb got %h want cccc", top);
        end
        issue(3'b001, 2'd0, 1'b1, 16'h1111);
        tests++;
        if (sif.acc_out !== 16'hCCCC || top !== 16'h1111 || count !== 2'd2) begin
            fails++;
            $display("FAIL swap_lk got acc=%h top=%h c=%0d want cccc/1111/2",
                     sif.acc_out, top, count);
        end
        issue(3'b000, 2'd0, 1'b1, 16'h4242);
        tests++;
        if (sif.acc_out !== 16'h4242 || top !== 16'h1111 || sif.res_valid !== 1'b1) begin
            fails++;
            $display("FAIL nop got acc=%h top=%h rv=%b want 4242/1111/1",
                     sif.acc_out, top, sif.res_valid);
        end
    endtask

    task automatic test_rotr();
        do_reset();
        issue(3'b001, 2'd0, 1'b0, 16'h0001);
        @(negedge clk);
        sif.op_valid = 1'b1;
        sif.op_code  = 3'b100;
        sif.op_arg   = 2'd3;
        sif.lk       = 1'b0;
        sif.acc_in   = 16'h5A5A;
        @(negedge clk);
        // a PUSH held only while busy must never be taken
        sif.op_code = 3'b101;
        sif.lk      = 1'b1;
        sif.acc_in  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (sif.op_ready !== 1'b0 || sif.res_valid !== 1'b0) begin
                fails++;
                $display("FAIL rotr_busy%0d got rdy=%b rv=%b want 0/0",
                         i, sif.op_ready, sif.res_valid);
            end
            if (i == 2) sif.op_valid = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (sif.res_valid !== 1'b1 || sif.acc_out !== 16'h5A5A || top !== 16'h1000
            || sif.op_ready !== 1'b1 || count !== 2'd0) begin
            fails++;
            $display("FAIL rotr_done got rv=%b acc=%h top=%h rdy=%b c=%0d want 1/5a5a/1000/1/0",
                     sif.res_valid, sif.acc_out, top, sif.op_ready, count);
        end
        @(negedge clk);
        tests++;
        if (sif.res_valid !== 1'b0) begin
            fails++; $display("FAIL rotr_pulse got rv=%b want 0", sif.res_valid);
        end
        issue(3'b100, 2'd0, 1'b1, 16'h2468);
        tests++;
        if (sif.res_valid !== 1'b1 || sif.acc_out !== 16'h2468 || top !== 16'h1000) begin
            fails++;
            $display("FAIL rotr0 got rv=%b acc=%h top=%h want 1/2468/1000",
                     sif.res_valid, sif.acc_out, top);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        issue(3'b101, 2'd0, 1'b1, 16'h1111);
        issue(3'b101, 2'd0, 1'b1, 16'h2222);
        issue(3'b101, 2'd0, 1'b1, 16'h3333);
        tests++;
        if (count !== 2'd2 || ovf !== 1'b1 || top !== 16'h3333) begin
            fails++;
            $display("FAIL ovf got c=%0d o=%b top=%h want 2/1/3333", count, ovf, top);
        end
        issue(3'b010, 2'd0, 1'b1, 16'h0);
        tests++;
        if (top !== 16'h2222 || ovf !== 1'b1) begin
            fails++; $display("FAIL ovf_second got top=%h o=%b want 2222/1", top, ovf);
        end
        issue(3'b111, 2'd0, 1'b1, 16'h0);
        tests++;
        if (ovf !== 1'b0 || count !== 2'd2) begin
            fails++; $display("FAIL clrf got o=%b c=%0d want 0/2", ovf, count);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(3'b110, 2'd0, 1'b0, 16'hABCD);
        tests++;
        if (sif.acc_out !== 16'hABC0 || unf !== 1'b1 || count !== 2'd0) begin
            fails++;
            $display("FAIL unf got acc=%h u=%b c=%0d want abc0/1/0", sif.acc_out, unf, count);
        end
        issue(3'b101, 2'd0, 1'b1, 16'h5678);
        issue(3'b110, 2'd0, 1'b1, 16'h0);
        tests++;
        if (sif.acc_out !== 16'h5678 || count !== 2'd0 || unf !== 1'b1 || top !== 16'h0) begin
            fails++;
            $display("FAIL pop_lk got acc=%h c=%0d u=%b top=%h want 5678/0/1/0000",
                     sif.acc_out, count, unf, top);
        end
    endtask

    task automatic test_rst_abort();
        int pulses;
        do_reset();
        issue(3'b001, 2'd0, 1'b1, 16'h00F0);
        issue(3'b100, 2'd3, 1'b1, 16'h0);
        @(negedge clk);
        tests++;
        if (top !== 16'h0F00) begin
            fails++; $display("FAIL abort_step got %h want 0f00", top);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (top !== 16'h0 || sif.op_ready !== 1'b1 || sif.res_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_rst got top=%h rdy=%b rv=%b want 0000/1/0",
                     top, sif.op_ready, sif.res_valid);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sif.res_valid === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL abort_pulse got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(3'b001, 2'd0, 1'b1, 16'h1234);
        issue(3'b100, 2'd1, 1'b1, 16'h7777);
        @(negedge clk);
        tests++;
        if (sif.res_valid !== 1'b1 || sif.op_ready !== 1'b1 || top !== 16'h2341
            || sif.acc_out !== 16'h7777) begin
            fails++;
            $display("FAIL b2b_rot got rv=%b rdy=%b top=%h acc=%h want 1/1/2341/7777",
                     sif.res_valid, sif.op_ready, top, sif.acc_out);
        end
        sif.op_valid = 1'b1;
        sif.op_code  = 3'b101;
        sif.op_arg   = 2'd0;
        sif.lk       = 1'b1;
        sif.acc_in   = 16'h9999;
        @(negedge clk);
        sif.op_valid = 1'b0;
        tests++;
        if (sif.res_valid !== 1'b1 || sif.acc_out !== 16'h9999 || top !== 16'h9999
            || count !== 2'd1) begin
            fails++;
            $display("FAIL b2b_push got rv=%b acc=%h top=%h c=%0d want 1/9999/9999/1",
                     sif.res_valid, sif.acc_out, top, count);
        end
    endtask

    initial begin
        sif.op_valid = 1'b0;
        sif.op_code  = 3'b000;
        sif.op_arg   = 2'd0;
        sif.lk       = 1'b0;
        sif.acc_in   = 16'h0;
        test_reset();
        test_swap_ul();
        test_push_rot();
        test_rotr();
        test_overflow();
        test_underflow();
        test_rst_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
